// File: rtl/block_emitter_pkg.sv
// Shared command codes, FSM encoding and ASCII constants for the block emitter.
package block_emitter_pkg;

  localparam logic [1:0] CMD_BEGIN  = 2'd0;
  localparam logic [1:0] CMD_END    = 2'd1;
  localparam logic [1:0] CMD_FILLER = 2'd2;
  localparam logic [1:0] CMD_NOP    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_SEP  = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_B     = 8'h62;
  localparam logic [7:0] ASCII_E     = 8'h65;
  localparam logic [7:0] ASCII_G     = 8'h67;
  localparam logic [7:0] ASCII_I     = 8'h69;
  localparam logic [7:0] ASCII_N     = 8'h6E;
  localparam logic [7:0] ASCII_D     = 8'h64;

  localparam logic [2:0] BEGIN_LAST_IDX = 3'd4;
  localparam logic [2:0] END_LAST_IDX   = 3'd2;

endpackage

// File: rtl/block_emitter_word_rom.sv
// block_word_rom: combinational (cmd, char index) -> character plus last-character flag.
module block_word_rom
  import block_emitter_pkg::*;
#(
  parameter logic [7:0] FILL_CHAR = 8'h78
) (
  input  logic [1:0] cmd_i,
  input  logic [2:0] idx_i,
  output logic [7:0] char_o,
  output logic       last_o
);

  // Word spelling lookup; out-of-range indices read as a space.
  always_comb begin
    char_o = ASCII_SPACE;
    last_o = 1'b1;
    case (cmd_i)
      CMD_BEGIN: begin
        last_o = (idx_i == BEGIN_LAST_IDX);
        case (idx_i)
          3'd0:    char_o = ASCII_B;
          3'd1:    char_o = ASCII_E;
          3'd2:    char_o = ASCII_G;
          3'd3:    char_o = ASCII_I;
          3'd4:    char_o = ASCII_N;
          default: char_o = ASCII_SPACE;
        endcase
      end
      CMD_END: begin
        last_o = (idx_i == END_LAST_IDX);
        case (idx_i)
          3'd0:    char_o = ASCII_E;
          3'd1:    char_o = ASCII_N;
          3'd2:    char_o = ASCII_D;
          default: char_o = ASCII_SPACE;
        endcase
      end
      CMD_FILLER: begin
        last_o = 1'b1;
        char_o = FILL_CHAR;
      end
      default: begin
        last_o = 1'b1;
        char_o = ASCII_SPACE;
      end
    endcase
  end

endmodule

// File: rtl/block_emitter.sv
// Emits "begin"/"end"/filler words with a trailing space and tracks nesting depth.
// Optional macro BLOCK_EMITTER_GUARD_EN rejects END at depth 0 and BEGIN at saturation.
module block_emitter
  import block_emitter_pkg::*;
#(
  parameter int unsigned DEPTH_W   = 8,
  parameter logic [7:0]  FILL_CHAR = 8'h78
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         cmd,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               err
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [1:0]         cmd_q, cmd_d;
  logic [2:0]         idx_q, idx_d;
  logic               last_q, last_d;
  logic [7:0]         out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               broken_q, broken_d;
  logic               balanced_q, balanced_d;
  logic               err_q, err_d;

  logic [1:0] rom_cmd;
  logic [2:0] rom_idx;
  logic [7:0] rom_char;
  logic       rom_last;
  logic       accept;
  logic       at_zero;
  logic       at_max;
  logic       reject;

  assign cmd_ready = reset && (state_q != ST_EMIT);
  assign accept    = cmd_valid && cmd_ready;
  assign at_zero   = (depth_q == {DEPTH_W{1'b0}});
  assign at_max    = (depth_q == DEPTH_MAX);

`ifdef BLOCK_EMITTER_GUARD_EN
  assign reject = accept && (((cmd == CMD_END) && at_zero) ||
                             ((cmd == CMD_BEGIN) && at_max));
`else
  assign reject = 1'b0;
`endif

  // While emitting, look ahead to the next character; otherwise the first char of the incoming cmd.
  always_comb begin
    rom_cmd = cmd;
    rom_idx = 3'd0;
    if (state_q == ST_EMIT) begin
      rom_cmd = cmd_q;
      rom_idx = idx_q + 3'd1;
    end else begin
      rom_cmd = cmd;
      rom_idx = 3'd0;
    end
  end

  block_word_rom #(
    .FILL_CHAR (FILL_CHAR)
  ) u_rom (
    .cmd_i  (rom_cmd),
    .idx_i  (rom_idx),
    .char_o (rom_char),
    .last_o (rom_last)
  );

  // Next-state, output and depth bookkeeping.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    last_d      = last_q;
    out_d       = ASCII_SPACE;
    out_valid_d = 1'b0;
    depth_d     = depth_q;
    broken_d    = broken_q;
    err_d       = reject;

    case (state_q)
      ST_EMIT: begin
        if (last_q) begin
          state_d     = ST_SEP;
          out_valid_d = 1'b1;
        end else begin
          idx_d       = idx_q + 3'd1;
          out_d       = rom_char;
          last_d      = rom_last;
          out_valid_d = 1'b1;
        end
      end
      ST_IDLE, ST_SEP: begin
        // A rejected command behaves like NOP so SEP still lasts a single cycle.
        if (accept && (cmd != CMD_NOP) && !reject) begin
          state_d     = ST_EMIT;
          cmd_d       = cmd;
          idx_d       = 3'd0;
          out_d       = rom_char;
          last_d      = rom_last;
          out_valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept && !reject) begin
      if (cmd == CMD_BEGIN) begin
        if (!at_max) begin
          depth_d = depth_q + DEPTH_ONE;
        end else begin
          depth_d = depth_q;
        end
      end else if (cmd == CMD_END) begin
        if (!at_zero) begin
          depth_d = depth_q - DEPTH_ONE;
        end else begin
          broken_d = 1'b1;
        end
      end else begin
        depth_d = depth_q;
      end
    end else begin
      depth_d = depth_q;
    end

    balanced_d = (depth_d == {DEPTH_W{1'b0}}) && !broken_d;
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_NOP;
      idx_q       <= 3'd0;
      last_q      <= 1'b0;
      out_q       <= ASCII_SPACE;
      out_valid_q <= 1'b0;
      depth_q     <= {DEPTH_W{1'b0}};
      broken_q    <= 1'b0;
      balanced_q  <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      depth_q     <= depth_d;
      broken_q    <= broken_d;
      balanced_q  <= balanced_d;
      err_q       <= err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign depth     = depth_q;
  assign balanced  = balanced_q;
  assign err       = err_q;

endmodule
